div_issue_ctrl: RTL and testbench

DIV_ISSUE_CTRL -- requirements
Module: div_issue_ctrl

---
 rtl/div_issue_ctrl.sv | 115 +++++++++++
 tb/tb_div_issue_ctrl.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/div_issue_ctrl.sv
// Issue/completion control between the EX stage and a multi-cycle divider, owning HI/LO.
// Optional feature: define DIV_ZERO_BYPASS_EN to resolve zero-divisor requests without the divider.
module div_issue_ctrl (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   input  logic        req_signed,
   input  logic [31:0] req_a,
   input  logic [31:0] req_b,
   input  logic        mthi,
   input  logic        mtlo,
   input  logic [31:0] mt_data,
   input  logic        flush,
   output logic        div_start,
   output logic        div_signed,
   output logic [31:0] div_a,
   output logic [31:0] div_b,
   input  logic [63:0] div_result,
   input  logic        div_ready,
   output logic        stall,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   typedef enum logic [1:0] {IDLE, BUSY, DRAIN} state_e;

   state_e      state_q, state_d;
   logic [31:0] hi_q, hi_d, lo_q, lo_d;
   logic [31:0] a_q, a_d, b_q, b_d;
   logic        sgn_q, sgn_d;
   logic        accept;
   logic        bypass;

`ifdef DIV_ZERO_BYPASS_EN
   assign bypass = (req_b == '0);
`else
   assign bypass = 1'b0;
`endif

   assign accept = (state_q == IDLE) && req_valid && !flush;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         hi_q    <= '0;
         lo_q    <= '0;
         a_q     <= '0;
         b_q     <= '0;
         sgn_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         a_q     <= a_d;
         b_q     <= b_d;
         sgn_q   <= sgn_d;
      end
   end

   always_comb begin
      state_d = state_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      a_d     = a_q;
      b_d     = b_q;
      sgn_d   = sgn_q;
      unique case (state_q)
         IDLE: begin
            if (!flush) begin
               if (mthi) hi_d = mt_data;
               if (mtlo) lo_d = mt_data;
               if (req_valid) begin
                  if (bypass) begin
                     hi_d = req_a;
                     lo_d = '1;
                  end else begin
                     state_d = BUSY;
                     a_d     = req_a;
                     b_d     = req_b;
                     sgn_d   = req_signed;
                  end
               end
            end
         end
         // A completion coinciding with flush still retires; waiting in DRAIN would never see another ready.
         BUSY: begin
            if (div_ready) begin
               hi_d    = div_result[63:32];
               lo_d    = div_result[31:0];
               state_d = IDLE;
            end else if (flush) begin
               state_d = DRAIN;
            end
         end
         DRAIN: begin
            if (div_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      div_start = !rst && (state_q != IDLE) && !div_ready;
      stall     = !rst && (accept
                           || ((state_q == BUSY) && !div_ready)
                           || ((state_q != IDLE) && (req_valid || mthi || mtlo)));
   end

   assign div_signed = sgn_q;
   assign div_a      = a_q;
   assign div_b      = b_q;
   assign hi         = hi_q;
   assign lo         = lo_q;

endmodule

// File: tb/tb_div_issue_ctrl.sv
// Randomized self-checking bench for div_issue_ctrl with a reactive divider stub and a reference model.
module tb_div_issue_ctrl;

`ifdef DIV_ZERO_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid, req_signed, mthi, mtlo, flush, div_ready;
   logic [31:0] req_a, req_b, mt_data;
   logic        div_start, div_signed, stall;
   logic [31:0] div_a, div_b, hi, lo;
   logic [63:0] div_result;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: 0 idle, 1 dividing, 2 dividing but squashed
   int          m_st;
   logic [31:0] m_hi, m_lo, m_a, m_b;
   logic        m_s;

   // Divider stub: -1 idle, otherwise cycles left until ready
   int mock_cnt = -1;
   int lat_lo   = 0;
   int lat_hi   = 5;

   div_issue_ctrl dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_signed(req_signed),
      .req_a(req_a), .req_b(req_b), .mthi(mthi), .mtlo(mtlo), .mt_data(mt_data),
      .flush(flush), .div_start(div_start), .div_signed(div_signed),
      .div_a(div_a), .div_b(div_b), .div_result(div_result), .div_ready(div_ready),
      .stall(stall), .hi(hi), .lo(lo)
   );

   always #5 clk = ~clk;

   function automatic logic [63:0] div_ref(input logic s, input logic [31:0] a, input logic [31:0] b);
      logic [31:0] q, r;
      if (b == 32'd0) begin
         q = '1;
         r = a;
      end else if (s) begin
         if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = a;
            r = '0;
         end else begin
            q = $signed(a) / $signed(b);
            r = $signed(a) % $signed(b);
         end
      end else begin
         q = a / b;
         r = a % b;
      end
      return {r, q};
   endfunction

   task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic cycle(input logic rv, input logic sg, input logic [31:0] a, input logic [31:0] b,
                        input logic mh, input logic ml, input logic [31:0] md, input logic fl);
      logic        rdy, acc, e_stall, e_start, start_s;
      logic [63:0] res, ref_res;
      @(negedge clk);
      rdy = 1'b0;
      res = {$urandom, $urandom};
      if (mock_cnt == 0) begin
         rdy = 1'b1;
         res = div_ref(div_signed, div_a, div_b);
      end else if (m_st == 0 && mock_cnt < 0 && $urandom_range(0, 15) == 0) begin
         rdy = 1'b1;
      end
      if (rdy && m_st == 1) fl = 1'b0;
      req_valid = rv; req_signed = sg; req_a = a; req_b = b;
      mthi = mh; mtlo = ml; mt_data = md; flush = fl;
      div_ready = rdy; div_result = res;
      #1;
      acc     = (m_st == 0) && rv && !fl;
      e_start = (m_st != 0) && !rdy;
      e_stall = acc || (m_st == 1 && !rdy) || (m_st != 0 && (rv || mh || ml));
      check_eq("stall", stall, e_stall);
      check_eq("div_start", div_start, e_start);
      check_eq("hi", hi, m_hi);
      check_eq("lo", lo, m_lo);
      if (m_st != 0) begin
         check_eq("div_a", div_a, m_a);
         check_eq("div_b", div_b, m_b);
         check_eq("div_signed", div_signed, m_s);
      end
      start_s = div_start;
      @(posedge clk);
      case (m_st)
         0: if (!fl) begin
               if (mh) m_hi = md;
               if (ml) m_lo = md;
               if (rv) begin
                  if (BYP && b == 32'd0) begin
                     m_hi = a;
                     m_lo = '1;
                  end else begin
                     m_st = 1; m_a = a; m_b = b; m_s = sg;
                  end
               end
            end
         1: if (rdy) begin
               ref_res = div_ref(m_s, m_a, m_b);
               m_hi = ref_res[63:32];
               m_lo = ref_res[31:0];
               m_st = 0;
            end else if (fl) begin
               m_st = 2;
            end
         default: if (rdy) m_st = 0;
      endcase
      if (mock_cnt == 0) mock_cnt = -1;
      else if (mock_cnt > 0) mock_cnt--;
      else if (start_s) mock_cnt = $urandom_range(lat_lo, lat_hi);
      #1;
   endtask

   task automatic idle_cycle();
      cycle(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, 1'b0);
   endtask

   task automatic run_until_idle(input int max);
      int n = 0;
      while (m_st != 0 && n < max) begin
         idle_cycle();
         n++;
      end
      check_eq("idle_timeout", m_st, 0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      req_valid = 1'b1; mthi = 1'b0; mtlo = 1'b0; flush = 1'b0; div_ready = 1'b0;
      #2 rst = 1'b1;
      #1;
      check_eq("rst_div_start", div_start, 0);
      check_eq("rst_stall", stall, 0);
      check_eq("rst_hi", hi, 0);
      check_eq("rst_lo", lo, 0);
      check_eq("rst_div_a", div_a, 0);
      check_eq("rst_div_b", div_b, 0);
      check_eq("rst_div_signed", div_signed, 0);
      m_st = 0; m_hi = '0; m_lo = '0; m_a = '0; m_b = '0; m_s = 1'b0;
      mock_cnt = -1;
      @(negedge clk);
      req_valid = 1'b0;
      rst = 1'b0;
   endtask

   initial begin
      logic        rv, sg, mh, ml, fl;
      logic [31:0] a, b, md;
      rst = 1'b1;
      req_valid = 1'b0; req_signed = 1'b0; req_a = '0; req_b = '0;
      mthi = 1'b0; mtlo = 1'b0; mt_data = '0; flush = 1'b0;
      div_ready = 1'b0; div_result = '0;
      m_st = 0; m_hi = '0; m_lo = '0; m_a = '0; m_b = '0; m_s = 1'b0;
      repeat (2) @(negedge clk);
      do_reset();

      // Unsigned 100/7
      lat_lo = 3; lat_hi = 3;
      cycle(1'b1, 1'b0, 32'd100, 32'd7, 1'b0, 1'b0, '0, 1'b0);
      run_until_idle(50);
      check_eq("u100_7_hi", hi, 32'd2);
      check_eq("u100_7_lo", lo, 32'd14);

      // Signed -7/2
      cycle(1'b1, 1'b1, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0, '0, 1'b0);
      run_until_idle(50);
      check_eq("s7_2_hi", hi, 32'hFFFF_FFFF);
      check_eq("s7_2_lo", lo, 32'hFFFF_FFFD);

      // Flush two cycles after acceptance leaves HI/LO untouched
      cycle(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 32'h1111_1111, 1'b0);
      cycle(1'b0, 1'b0, '0, '0, 1'b0, 1'b1, 32'h2222_2222, 1'b0);
      lat_lo = 6; lat_hi = 6;
      cycle(1'b1, 1'b0, 32'd100, 32'd7, 1'b0, 1'b0, '0, 1'b0);
      idle_cycle();
      cycle(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, 1'b1);
      check_eq("drain_state", m_st, 2);
      run_until_idle(50);
      check_eq("drain_hi", hi, 32'h1111_1111);
      check_eq("drain_lo", lo, 32'h2222_2222);
      lat_lo = 2; lat_hi = 2;
      cycle(1'b1, 1'b0, 32'd9, 32'd3, 1'b0, 1'b0, '0, 1'b0);
      run_until_idle(50);
      check_eq("u9_3_hi", hi, 32'd0);
      check_eq("u9_3_lo", lo, 32'd3);

      // mthi held during a divide lands one cycle after the result
      cycle(1'b1, 1'b0, 32'd20, 32'd7, 1'b0, 1'b0, '0, 1'b0);
      for (int i = 0; i < 50 && m_st != 0; i++)
         cycle(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 32'hDEAD_BEEF, 1'b0);
      check_eq("mthi_div_hi", hi, 32'd6);
      check_eq("mthi_div_lo", lo, 32'd2);
      cycle(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 32'hDEAD_BEEF, 1'b0);
      check_eq("mthi_hi", hi, 32'hDEAD_BEEF);

      // Request held across completion is accepted the cycle after
      cycle(1'b1, 1'b0, 32'd30, 32'd4, 1'b0, 1'b0, '0, 1'b0);
      for (int i = 0; i < 50 && m_st != 0; i++)
         cycle(1'b1, 1'b0, 32'd30, 32'd4, 1'b0, 1'b0, '0, 1'b0);
      cycle(1'b1, 1'b0, 32'd30, 32'd4, 1'b0, 1'b0, '0, 1'b0);
      check_eq("b2b_busy", m_st, 1);
      run_until_idle(50);

      // Reset mid-divide, then 20/4
      cycle(1'b1, 1'b0, 32'd50, 32'd3, 1'b0, 1'b0, '0, 1'b0);
      idle_cycle();
      do_reset();
      cycle(1'b1, 1'b0, 32'd20, 32'd4, 1'b0, 1'b0, '0, 1'b0);
      run_until_idle(50);
      check_eq("u20_4_hi", hi, 32'd0);
      check_eq("u20_4_lo", lo, 32'd5);

      // Zero divisor: bypassed or passed through, same architectural result
      cycle(1'b1, 1'b0, 32'd5, 32'd0, 1'b0, 1'b0, '0, 1'b0);
      run_until_idle(50);
      check_eq("div0_hi", hi, 32'd5);
      check_eq("div0_lo", lo, 32'hFFFF_FFFF);

      lat_lo = 0; lat_hi = 5;
      for (int i = 0; i < 3000; i++) begin
         rv = ($urandom_range(0, 3) == 0);
         sg = $urandom_range(0, 1);
         a  = ($urandom_range(0, 1) == 0) ? $urandom : $urandom_range(0, 200);
         case ($urandom_range(0, 7))
            0:       b = '0;
            1, 2:    b = $urandom_range(1, 20);
            3:       b = 32'hFFFF_FFFF;
            default: b = $urandom;
         endcase
         mh = ($urandom_range(0, 9) == 0);
         ml = ($urandom_range(0, 9) == 0);
         md = $urandom;
         fl = ($urandom_range(0, 9) == 0);
         if (BYP && m_st == 0 && rv) begin
            mh = 1'b0;
            ml = 1'b0;
         end
         cycle(rv, sg, a, b, mh, ml, md, fl);
         if ($urandom_range(0, 299) == 0) do_reset();
      end
      run_until_idle(50);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
